// File: rtl/adam_boot_seq_if.sv
// Pause/resume and boot-address bundle between the boot sequencer and the SoC targets.
// Combinational wiring only; handshake is level-based pause/ack per target.
// Master = sequencer, slave = targets plus the reboot requester.
interface adam_boot_seq_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int NO_CPUS    = 1,
    parameter int NO_MEMS    = 3
);
    logic [NO_MEMS-1:0]    mem_pause_o;
    logic [NO_MEMS-1:0]    mem_pause_ack_i;
    logic [NO_CPUS-1:0]    cpu_pause_o;
    logic [NO_CPUS-1:0]    cpu_pause_ack_i;
    logic [ADDR_WIDTH-1:0] boot_addr_o;
    logic                  reboot_req_i;
    logic [ADDR_WIDTH-1:0] reboot_addr_i;
    logic                  done_o;
    logic                  error_o;

    modport master (
        output mem_pause_o,
        input  mem_pause_ack_i,
        output cpu_pause_o,
        input  cpu_pause_ack_i,
        output boot_addr_o,
        input  reboot_req_i,
        input  reboot_addr_i,
        output done_o,
        output error_o
    );

    modport slave (
        input  mem_pause_o,
        output mem_pause_ack_i,
        input  cpu_pause_o,
        output cpu_pause_ack_i,
        input  boot_addr_o,
        output reboot_req_i,
        output reboot_addr_i,
        input  done_o,
        input  error_o
    );
endinterface

// File: rtl/adam_boot_seq.sv
// Post-reset boot sequencer: hold, wake memories, wake CPUs, run; software reboot re-runs it.
// Latency: all outputs registered, one cycle after the state decision; per-step watchdog.
// Backpressure: waits on level acks of enabled targets; reboot requests outside RUN are dropped.
module adam_boot_seq #(
    parameter int                     ADDR_WIDTH     = 32,
    parameter int                     NO_CPUS        = 1,
    parameter int                     NO_MEMS        = 3,
    parameter int                     RST_CYCLES     = 5,
    parameter int                     TIMEOUT_CYCLES = 1024,
    parameter logic [ADDR_WIDTH-1:0]  RST_BOOT_ADDR  = '0,
    parameter logic [NO_CPUS-1:0]     BOOT_CPU_MASK  = 1,
    parameter logic [NO_MEMS-1:0]     BOOT_MEM_MASK  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    adam_boot_seq_if.master bus
);
    localparam int CNT_MAX = (RST_CYCLES > TIMEOUT_CYCLES) ? RST_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_TOP   = CW'(CNT_MAX);

    typedef enum logic [2:0] {
        HOLD, MEM_WAKE, CPU_WAKE, RUN, PAUSE_ALL, ERROR
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q;
    logic [ADDR_WIDTH-1:0] reboot_addr_q;
    logic                  mem_woken, cpu_woken, all_paused;
    logic                  latch_addr, load_boot;

    always_comb begin
        state_d    = state_q;
        latch_addr = 1'b0;
        load_boot  = 1'b0;
        mem_woken  = (bus.mem_pause_ack_i & BOOT_MEM_MASK) == '0;
        cpu_woken  = (bus.cpu_pause_ack_i & BOOT_CPU_MASK) == '0;
        all_paused = ((bus.mem_pause_ack_i & BOOT_MEM_MASK) == BOOT_MEM_MASK) &&
                     ((bus.cpu_pause_ack_i & BOOT_CPU_MASK) == BOOT_CPU_MASK);
        // Completion is tested before the watchdog so it wins a same-cycle tie.
        case (state_q)
            HOLD: begin
                if (cnt_q == HOLD_LAST) state_d = MEM_WAKE;
            end
            MEM_WAKE: begin
                if (mem_woken)             state_d = CPU_WAKE;
                else if (cnt_q == TO_LAST) state_d = ERROR;
            end
            CPU_WAKE: begin
                if (cpu_woken)             state_d = RUN;
                else if (cnt_q == TO_LAST) state_d = ERROR;
            end
            RUN: begin
                if (bus.reboot_req_i) begin
                    latch_addr = 1'b1;
                    state_d    = PAUSE_ALL;
                end
            end
            PAUSE_ALL: begin
                if (all_paused) begin
                    load_boot = 1'b1;
                    state_d   = HOLD;
                end else if (cnt_q == TO_LAST) begin
                    state_d = ERROR;
                end
            end
            ERROR:   state_d = ERROR;
            default: state_d = ERROR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= HOLD;
            cnt_q           <= '0;
            reboot_addr_q   <= RST_BOOT_ADDR;
            bus.mem_pause_o <= '1;
            bus.cpu_pause_o <= '1;
            bus.boot_addr_o <= RST_BOOT_ADDR;
            bus.done_o      <= 1'b0;
            bus.error_o     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q)  cnt_q <= '0;
            else if (cnt_q != CNT_TOP) cnt_q <= cnt_q + CW'(1);
            if (latch_addr) reboot_addr_q <= bus.reboot_addr_i;
            // The address only moves on the PAUSE_ALL exit, i.e. with every enabled CPU acked paused.
            if (load_boot)  bus.boot_addr_o <= reboot_addr_q;
            bus.mem_pause_o <= (state_d inside {MEM_WAKE, CPU_WAKE, RUN}) ? ~BOOT_MEM_MASK : '1;
            bus.cpu_pause_o <= (state_d inside {CPU_WAKE, RUN}) ? ~BOOT_CPU_MASK : '1;
            bus.done_o      <= (state_d == RUN);
            bus.error_o     <= bus.error_o | (state_d == ERROR);
        end
    end
endmodule

// File: tb/tb_adam_boot_seq.sv
// Directed bench for adam_boot_seq: cycle table for boot/reboot, plus reset, timeout and zero-mask sequences.
module tb_adam_boot_seq;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adam_boot_seq_if #(.ADDR_WIDTH(32), .NO_CPUS(1), .NO_MEMS(3)) bus0();
    adam_boot_seq_if #(.ADDR_WIDTH(32), .NO_CPUS(2), .NO_MEMS(3)) bus1();

    adam_boot_seq #(
        .ADDR_WIDTH(32), .NO_CPUS(1), .NO_MEMS(3), .RST_CYCLES(5), .TIMEOUT_CYCLES(1024),
        .RST_BOOT_ADDR(32'h0), .BOOT_CPU_MASK(1'b1), .BOOT_MEM_MASK(3'b001)
    ) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    adam_boot_seq #(
        .ADDR_WIDTH(32), .NO_CPUS(2), .NO_MEMS(3), .RST_CYCLES(5), .TIMEOUT_CYCLES(64),
        .RST_BOOT_ADDR(32'h0000_0100), .BOOT_CPU_MASK(2'b00), .BOOT_MEM_MASK(3'b001)
    ) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // Target model: each ack follows its pause request two cycles later.
    logic [2:0] m0_d1 = '1, m0_d2 = '1, m1_d1 = '1, m1_d2 = '1;
    logic       c0_d1 = 1'b1, c0_d2 = 1'b1;
    logic [1:0] c1_d1 = '1, c1_d2 = '1;
    logic       freeze0    = 1'b0;
    logic [2:0] mem_force0 = 3'b000;

    always @(posedge clk) begin
        if (!freeze0) begin
            m0_d1 <= bus0.mem_pause_o; m0_d2 <= m0_d1;
            c0_d1 <= bus0.cpu_pause_o; c0_d2 <= c0_d1;
        end
        m1_d1 <= bus1.mem_pause_o; m1_d2 <= m1_d1;
        c1_d1 <= bus1.cpu_pause_o; c1_d2 <= c1_d1;
    end

    assign bus0.mem_pause_ack_i = m0_d2 | mem_force0;
    assign bus0.cpu_pause_ack_i = c0_d2;
    assign bus1.mem_pause_ack_i = m1_d2;
    assign bus1.cpu_pause_ack_i = c1_d2;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic [2:0]  mem;
        logic        cpu;
        logic        done;
        logic        err;
        logic [31:0] boot;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic req, input logic [31:0] addr, input logic [2:0] mem,
                       input logic cpu, input logic done, input logic [31:0] boot, input int count);
        vec_t v;
        v.req = req; v.addr = addr; v.mem = mem; v.cpu = cpu;
        v.done = done; v.err = 1'b0; v.boot = boot;
        for (int k = 0; k < count; k++) vq.push_back(v);
    endtask

    function automatic logic [63:0] obs0();
        return {26'd0, bus0.mem_pause_o, bus0.cpu_pause_o, bus0.done_o, bus0.error_o, bus0.boot_addr_o};
    endfunction

    initial begin
        int n;
        logic cpu_ok;

        // One entry per clock edge after reset release (edge 1 first).
        add(0, 32'h0,         3'b111, 1, 0, 32'h0,         4); // HOLD
        add(0, 32'h0,         3'b110, 1, 0, 32'h0,         3); // MEM_WAKE
        add(0, 32'h0,         3'b110, 0, 0, 32'h0,         3); // CPU_WAKE
        add(0, 32'h0,         3'b110, 0, 1, 32'h0,         1); // RUN
        add(1, 32'h0000_8000, 3'b111, 1, 0, 32'h0,         1); // reboot accepted
        add(0, 32'h0,         3'b111, 1, 0, 32'h0,         2); // PAUSE_ALL
        add(0, 32'h0,         3'b111, 1, 0, 32'h0000_8000, 5); // HOLD, new address
        add(0, 32'h0,         3'b110, 1, 0, 32'h0000_8000, 3); // MEM_WAKE
        add(0, 32'h0,         3'b110, 0, 0, 32'h0000_8000, 1); // CPU_WAKE
        add(1, 32'hDEAD_BEEF, 3'b110, 0, 0, 32'h0000_8000, 1); // reboot in CPU_WAKE ignored
        add(0, 32'h0,         3'b110, 0, 0, 32'h0000_8000, 1);
        add(0, 32'h0,         3'b110, 0, 1, 32'h0000_8000, 3); // RUN again

        bus0.reboot_req_i  = 1'b0; bus0.reboot_addr_i = '0;
        bus1.reboot_req_i  = 1'b0; bus1.reboot_addr_i = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset0", obs0(), {26'd0, 3'b111, 1'b1, 1'b0, 1'b0, 32'h0});
        check("reset1", {bus1.mem_pause_o, bus1.cpu_pause_o, bus1.done_o, bus1.error_o, bus1.boot_addr_o},
              {3'b111, 2'b11, 1'b0, 1'b0, 32'h0000_0100});
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            bus0.reboot_req_i  = vq[i].req;
            bus0.reboot_addr_i = vq[i].addr;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), obs0(),
                  {26'd0, vq[i].mem, vq[i].cpu, vq[i].done, vq[i].err, vq[i].boot});
            @(negedge clk);
        end
        bus0.reboot_req_i = 1'b0;

        // Reboot, stall targets in PAUSE_ALL, then async reset mid-cycle.
        freeze0 = 1'b1;
        bus0.reboot_req_i = 1'b1; bus0.reboot_addr_i = 32'h0000_1234;
        @(posedge clk); #1;
        check("pause_all_entry", obs0(), {26'd0, 3'b111, 1'b1, 1'b0, 1'b0, 32'h0000_8000});
        @(negedge clk) bus0.reboot_req_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pause_all_stall", obs0(), {26'd0, 3'b111, 1'b1, 1'b0, 1'b0, 32'h0000_8000});
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", obs0(), {26'd0, 3'b111, 1'b1, 1'b0, 1'b0, 32'h0});
        @(negedge clk);
        freeze0 = 1'b0;
        rst_n   = 1'b1;
        n = 0;
        while (!bus0.done_o && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("reboot_after_reset_edges", n, 11);
        check("reboot_addr_discarded", bus0.boot_addr_o, 32'h0);

        // Zero CPU mask: CPU_WAKE is a single cycle, CPUs stay paused.
        @(negedge clk) rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        n = 0; cpu_ok = 1'b1;
        while (!bus1.done_o && n < 50) begin
            @(posedge clk); #1; n++;
            if (bus1.cpu_pause_o !== 2'b11) cpu_ok = 1'b0;
        end
        check("nocpu_done_edge", n, 9);
        check("nocpu_cpu_paused", cpu_ok, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("nocpu_run_outputs", {bus1.mem_pause_o, bus1.cpu_pause_o, bus1.done_o, bus1.error_o, bus1.boot_addr_o},
              {3'b110, 2'b11, 1'b1, 1'b0, 32'h0000_0100});

        // Memory 0 never resumes: watchdog fires exactly TIMEOUT_CYCLES after MEM_WAKE entry.
        @(negedge clk) begin rst_n = 1'b0; mem_force0 = 3'b001; end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        n = 0;
        while (bus0.mem_pause_o[0] !== 1'b0 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("mem_wake_edge", n, 5);
        n = 0; cpu_ok = 1'b1;
        while (!bus0.error_o && n < 2000) begin
            @(posedge clk); #1; n++;
            if (bus0.cpu_pause_o !== 1'b1) cpu_ok = 1'b0;
        end
        check("timeout_cycles", n, 1024);
        check("timeout_cpu_paused", cpu_ok, 1'b1);
        check("error_outputs", obs0(), {26'd0, 3'b111, 1'b1, 1'b0, 1'b1, 32'h0});
        @(negedge clk) mem_force0 = 3'b000;
        bus0.reboot_req_i = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("error_terminal", obs0(), {26'd0, 3'b111, 1'b1, 1'b0, 1'b1, 32'h0});
        bus0.reboot_req_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
